// File: rtl/cirno9_iob_pkg.sv
`default_nettype none
// ============================================================================
// cirno9_iob_pkg : shared state encoding and field widths for the iob arbiter
// Revision: 1.0
// ============================================================================
package cirno9_iob_pkg;

  localparam int ADR_W = 32;
  localparam int WEN_W = 4;
  localparam int DAT_W = 32;

  localparam logic [DAT_W-1:0] IOB_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } iob_state_t;

endpackage
`default_nettype wire

// File: rtl/cirno9_iob_rr2.sv
`default_nettype none
// ============================================================================
// cirno9_iob_rr2 : 2-way round-robin picker, a tie goes to the master not served last
// Revision: 1.0
// ============================================================================
module cirno9_iob_rr2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_gnt,
  output logic       o_any
);

  assign o_any = |i_req;
  assign o_gnt = (i_req == 2'b11) ? ~i_last : i_req[1];

endmodule
`default_nettype wire

// File: rtl/cirno9_iob_arb.sv
`default_nettype none
// ============================================================================
// cirno9_iob_arb : two-master round-robin arbiter for the iob bus with timeout watchdog
// Revision: 1.0
// ============================================================================
module cirno9_iob_arb
  import cirno9_iob_pkg::*;
#(
  parameter int               TIMEOUT  = 16,
  parameter logic [DAT_W-1:0] ERR_DATA = IOB_ERR_DATA,
  parameter int               CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             m0_iob_val,
  output logic             m0_iob_rdy,
  input  logic [ADR_W-1:0] m0_iob_adr,
  input  logic [WEN_W-1:0] m0_iob_wen,
  input  logic [DAT_W-1:0] m0_iob_wdat,
  output logic [DAT_W-1:0] m0_iob_rdat,

  input  logic             m1_iob_val,
  output logic             m1_iob_rdy,
  input  logic [ADR_W-1:0] m1_iob_adr,
  input  logic [WEN_W-1:0] m1_iob_wen,
  input  logic [DAT_W-1:0] m1_iob_wdat,
  output logic [DAT_W-1:0] m1_iob_rdat,

  output logic             iob_val,
  input  logic             iob_rdy,
  output logic [ADR_W-1:0] iob_adr,
  output logic [WEN_W-1:0] iob_wen,
  output logic [DAT_W-1:0] iob_wdat,
  input  logic [DAT_W-1:0] iob_rdat,

  output logic             tout_err,
  output logic [ADR_W-1:0] tout_adr
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  iob_state_t       r_state, w_state_nx;
  logic             r_gnt, w_gnt_nx;
  logic             r_last, w_last_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [ADR_W-1:0] r_tout_adr, w_tout_adr_nx;

  logic             w_pick;
  logic             w_any;
  logic             w_gval;
  logic             w_busy;
  logic             w_err;
  logic             w_done;
  logic [DAT_W-1:0] w_rdat;

  cirno9_iob_rr2 u_rr2 (
    .i_req  ({m1_iob_val, m0_iob_val}),
    .i_last (r_last),
    .o_gnt  (w_pick),
    .o_any  (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= 1'b0;
      r_last     <= 1'b1;
      r_cnt      <= '0;
      r_tout_adr <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_gnt      <= w_gnt_nx;
      r_last     <= w_last_nx;
      r_cnt      <= w_cnt_nx;
      r_tout_adr <= w_tout_adr_nx;
    end
  end

  // Payload always follows the registered grant; only iob_val is gated by state.
  assign w_gval   = r_gnt ? m1_iob_val  : m0_iob_val;
  assign iob_adr  = r_gnt ? m1_iob_adr  : m0_iob_adr;
  assign iob_wen  = r_gnt ? m1_iob_wen  : m0_iob_wen;
  assign iob_wdat = r_gnt ? m1_iob_wdat : m0_iob_wdat;

  always_comb begin
    w_state_nx    = r_state;
    w_gnt_nx      = r_gnt;
    w_last_nx     = r_last;
    w_cnt_nx      = r_cnt;
    w_tout_adr_nx = r_tout_adr;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nx = ST_BUSY;
          w_gnt_nx   = w_pick;
          w_cnt_nx   = '0;
        end
      end
      ST_BUSY: begin
        if (iob_rdy) begin
          w_last_nx  = r_gnt;
          w_state_nx = ST_IDLE;
        end else if (w_gval) begin
          w_cnt_nx = r_cnt + c_CNT_ONE;
          if (r_cnt == c_CNT_LAST) begin
            w_state_nx    = ST_ERR;
            w_tout_adr_nx = iob_adr;
          end
        end else begin
          // requester withdrew mid-transaction: abandon without touching fairness
          w_state_nx = ST_IDLE;
        end
      end
      ST_ERR: begin
        w_last_nx  = r_gnt;
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  assign w_busy = (r_state == ST_BUSY);
  assign w_err  = (r_state == ST_ERR);
  assign w_done = (w_busy & iob_rdy) | w_err;
  assign w_rdat = w_err ? ERR_DATA : iob_rdat;

  assign iob_val     = w_busy & w_gval;
  assign m0_iob_rdy  = w_done & ~r_gnt;
  assign m1_iob_rdy  = w_done & r_gnt;
  assign m0_iob_rdat = m0_iob_rdy ? w_rdat : '0;
  assign m1_iob_rdat = m1_iob_rdy ? w_rdat : '0;
  assign tout_err    = w_err;
  assign tout_adr    = r_tout_adr;

endmodule
`default_nettype wire

// File: tb/tb_cirno9_iob_arb.sv
`default_nettype none
// ============================================================================
// tb_cirno9_iob_arb : directed self-checking bench for the cirno9 iob arbiter
// Revision: 1.0
// ============================================================================
module tb_cirno9_iob_arb;

  logic        clk;
  logic        rst_n;
  logic        m0_iob_val, m0_iob_rdy;
  logic [31:0] m0_iob_adr, m0_iob_wdat, m0_iob_rdat;
  logic [3:0]  m0_iob_wen;
  logic        m1_iob_val, m1_iob_rdy;
  logic [31:0] m1_iob_adr, m1_iob_wdat, m1_iob_rdat;
  logic [3:0]  m1_iob_wen;
  logic        iob_val, iob_rdy;
  logic [31:0] iob_adr, iob_wdat, iob_rdat;
  logic [3:0]  iob_wen;
  logic        tout_err;
  logic [31:0] tout_adr;

  int n_tot;
  int n_bad;

  localparam logic [31:0] c_A0 = 32'h0000_0A00;
  localparam logic [31:0] c_A1 = 32'h0000_0A11;

  cirno9_iob_arb u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_iob_val  (m0_iob_val),
    .m0_iob_rdy  (m0_iob_rdy),
    .m0_iob_adr  (m0_iob_adr),
    .m0_iob_wen  (m0_iob_wen),
    .m0_iob_wdat (m0_iob_wdat),
    .m0_iob_rdat (m0_iob_rdat),
    .m1_iob_val  (m1_iob_val),
    .m1_iob_rdy  (m1_iob_rdy),
    .m1_iob_adr  (m1_iob_adr),
    .m1_iob_wen  (m1_iob_wen),
    .m1_iob_wdat (m1_iob_wdat),
    .m1_iob_rdat (m1_iob_rdat),
    .iob_val     (iob_val),
    .iob_rdy     (iob_rdy),
    .iob_adr     (iob_adr),
    .iob_wen     (iob_wen),
    .iob_wdat    (iob_wdat),
    .iob_rdat    (iob_rdat),
    .tout_err    (tout_err),
    .tout_adr    (tout_adr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    n_tot = 0;
    n_bad = 0;
    rst_n = 1'b0;
    m0_iob_val = 0; m0_iob_adr = 0; m0_iob_wen = 0; m0_iob_wdat = 0;
    m1_iob_val = 0; m1_iob_adr = 0; m1_iob_wen = 0; m1_iob_wdat = 0;
    iob_rdy = 0; iob_rdat = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iob_val", 32'(iob_val), 32'd0);
    chk("rst_m0_rdy", 32'(m0_iob_rdy), 32'd0);
    chk("rst_m1_rdy", 32'(m1_iob_rdy), 32'd0);
    chk("rst_tout_err", 32'(tout_err), 32'd0);
    chk("rst_tout_adr", tout_adr, 32'd0);
    rst_n = 1'b1;

    // single read from m0
    step();
    m0_iob_val = 1; m0_iob_adr = 32'h3000_0010;
    #1 chk("rd_idle_val", 32'(iob_val), 32'd0);
    step();
    #1 chk("rd_iob_val", 32'(iob_val), 32'd1);
    chk("rd_iob_adr", iob_adr, 32'h3000_0010);
    iob_rdy = 1; iob_rdat = 32'h1234_5678;
    #1 chk("rd_m0_rdy", 32'(m0_iob_rdy), 32'd1);
    chk("rd_m0_rdat", m0_iob_rdat, 32'h1234_5678);
    chk("rd_m1_rdy", 32'(m1_iob_rdy), 32'd0);
    chk("rd_m1_rdat", m1_iob_rdat, 32'd0);
    step();
    m0_iob_val = 0; iob_rdy = 0; iob_rdat = 0;
    #1 chk("rd_after_val", 32'(iob_val), 32'd0);
    chk("rd_after_rdy", 32'(m0_iob_rdy), 32'd0);
    chk("rd_after_rdat", m0_iob_rdat, 32'd0);

    // contention: alternating grants starting with m0 after reset
    reset_dut();
    m0_iob_val = 1; m0_iob_adr = c_A0;
    m1_iob_val = 1; m1_iob_adr = c_A1;
    for (int t = 0; t < 4; t++) begin
      step();
      #1 chk("ct_iob_val", 32'(iob_val), 32'd1);
      chk("ct_iob_adr", iob_adr, (t % 2 == 1) ? c_A1 : c_A0);
      iob_rdy = 1; iob_rdat = 32'h100 + 32'(t);
      #1 chk("ct_m0_rdy", 32'(m0_iob_rdy), (t % 2 == 0) ? 32'd1 : 32'd0);
      chk("ct_m1_rdy", 32'(m1_iob_rdy), (t % 2 == 1) ? 32'd1 : 32'd0);
      step();
      iob_rdy = 0;
      #1 chk("ct_bubble", 32'(iob_val), 32'd0);
    end
    m0_iob_val = 0; m1_iob_val = 0;

    // write pass-through from m1
    step();
    m1_iob_val = 1; m1_iob_adr = 32'h1000_0004; m1_iob_wen = 4'b0011; m1_iob_wdat = 32'hA5A5_0000;
    step();
    #1 chk("wr_iob_val", 32'(iob_val), 32'd1);
    chk("wr_iob_adr", iob_adr, 32'h1000_0004);
    chk("wr_iob_wen", 32'(iob_wen), 32'h3);
    chk("wr_iob_wdat", iob_wdat, 32'hA5A5_0000);
    iob_rdy = 1;
    #1 chk("wr_m1_rdy", 32'(m1_iob_rdy), 32'd1);
    chk("wr_m0_rdy", 32'(m0_iob_rdy), 32'd0);
    step();
    m1_iob_val = 0; m1_iob_wen = 0; iob_rdy = 0;

    // timeout on m0
    m0_iob_val = 1; m0_iob_adr = 32'h5000_0000;
    step();
    for (int i = 0; i < 16; i++) begin
      #1 chk("to_busy_val", 32'(iob_val), 32'd1);
      chk("to_busy_rdy", 32'(m0_iob_rdy), 32'd0);
      step();
    end
    #1 chk("to_m0_rdy", 32'(m0_iob_rdy), 32'd1);
    chk("to_m0_rdat", m0_iob_rdat, 32'hDEAD_BEEF);
    chk("to_err", 32'(tout_err), 32'd1);
    chk("to_iob_val", 32'(iob_val), 32'd0);
    chk("to_adr", tout_adr, 32'h5000_0000);
    iob_rdy = 1; iob_rdat = 32'h1111_1111;
    #1 chk("to_late_rdat", m0_iob_rdat, 32'hDEAD_BEEF);
    step();
    m0_iob_val = 0;
    #1 chk("to_late_rdy", 32'(m0_iob_rdy), 32'd0);
    chk("to_err_pulse", 32'(tout_err), 32'd0);
    chk("to_adr_sticky", tout_adr, 32'h5000_0000);
    iob_rdy = 0; iob_rdat = 0;

    // asynchronous reset while busy
    step();
    m0_iob_val = 1; m0_iob_adr = c_A0;
    step();
    #1 chk("ar_busy", 32'(iob_val), 32'd1);
    iob_rdy = 1;
    #1 chk("ar_rdy_pre", 32'(m0_iob_rdy), 32'd1);
    #1 rst_n = 0;
    #1 chk("ar_iob_val", 32'(iob_val), 32'd0);
    chk("ar_m0_rdy", 32'(m0_iob_rdy), 32'd0);
    chk("ar_m0_rdat", m0_iob_rdat, 32'd0);
    chk("ar_tout_adr", tout_adr, 32'd0);
    @(posedge clk);
    #1 rst_n = 1; iob_rdy = 0;
    m1_iob_val = 1; m1_iob_adr = c_A1;
    step();
    #1 chk("ar_post_val", 32'(iob_val), 32'd1);
    chk("ar_post_adr", iob_adr, c_A0);
    iob_rdy = 1;
    #1 chk("ar_post_m0", 32'(m0_iob_rdy), 32'd1);
    chk("ar_post_m1", 32'(m1_iob_rdy), 32'd0);
    step();
    m0_iob_val = 0; m1_iob_val = 0; iob_rdy = 0;

    // abort: m1 granted (m0 served last), then withdraws
    step();
    m0_iob_val = 1; m1_iob_val = 1;
    step();
    #1 chk("ab_gnt_adr", iob_adr, c_A1);
    m0_iob_val = 0; m1_iob_val = 0;
    #1 chk("ab_drop_val", 32'(iob_val), 32'd0);
    chk("ab_drop_rdy", 32'(m1_iob_rdy), 32'd0);
    step();
    #1 chk("ab_idle_rdy", 32'(m1_iob_rdy), 32'd0);
    chk("ab_idle_val", 32'(iob_val), 32'd0);
    m0_iob_val = 1; m1_iob_val = 1;
    step();
    #1 chk("ab_last_kept", iob_adr, c_A1);
    iob_rdy = 1;
    #1 chk("ab_m1_rdy", 32'(m1_iob_rdy), 32'd1);
    step();
    m0_iob_val = 0; m1_iob_val = 0; iob_rdy = 0;
    step();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cirno9_iob_arb.md
Name: cirno9_iob_arb

Overview:
Two-master arbiter for the cirno9 iob bus. It sits between two requesters (m0 = core data port, m1 = debug/DMA master) and the single iob port that feeds the address decoder.
- Round-robin grant, one transaction in flight at a time.
- The granted master's request is forwarded unchanged.
- A watchdog completes any transaction that gets no slave response, so an unmapped address cannot hang the core.

Parameters:
TIMEOUT, 16, number of BUSY cycles without iob_rdy before the arbiter forces a completion (legal range 2..256)
ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out transaction
CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W >= TIMEOUT

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
m0_iob_val  in  1  m0 request valid; held with payload until m0_iob_rdy
m0_iob_rdy  out  1  m0 completion strobe (1 cycle)
m0_iob_adr  in  32  m0 address
m0_iob_wen  in  4  m0 byte write enables (0 = read)
m0_iob_wdat  in  32  m0 write data
m0_iob_rdat  out  32  m0 read data, valid only while m0_iob_rdy=1
m1_iob_val / m1_iob_rdy / m1_iob_adr / m1_iob_wen / m1_iob_wdat / m1_iob_rdat: same as m0, for master 1
iob_val  out  1  downstream request valid
iob_rdy  in  1  downstream completion
iob_adr  out  32  downstream address
iob_wen  out  4  downstream byte enables
iob_wdat  out  32  downstream write data
iob_rdat  in  32  downstream read data
tout_err  out  1  1-cycle pulse when a timeout completion is issued
tout_adr  out  32  address of the most recent timed-out transaction (sticky)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, gnt=0, last=1 (so m0 wins the first tie), cnt=0, tout_adr=0.
  - All outputs 0, except iob_adr/wen/wdat, which are a function of gnt.
- Downstream payload mux:
  - iob_adr/wen/wdat = payload of master gnt, at all times.
  - iob_val = (state==BUSY) & m{gnt}_iob_val.
- IDLE:
  - no val: stay in IDLE.
  - exactly one val: gnt := that master.
  - both val: gnt := ~last.
  - Any val: next state BUSY, cnt := 0. Grant is registered, so the first iob_val appears 1 cycle after m*_val.
- BUSY, iob_rdy=1:
  - m{gnt}_iob_rdy=1, m{gnt}_iob_rdat=iob_rdat (combinational pass-through).
  - last := gnt, next state IDLE.
  - Minimum transaction = 2 cycles (grant + response); back-to-back requests see a 1-cycle IDLE bubble.
- BUSY, iob_rdy=0, m{gnt}_val=1:
  - cnt := cnt+1.
  - If cnt==TIMEOUT-1: next state ERR, tout_adr := m{gnt}_iob_adr.
- BUSY, granted master drops val (protocol violation): abort, next state IDLE, no rdy, last unchanged.
- ERR (1 cycle):
  - iob_val=0, m{gnt}_iob_rdy=1, m{gnt}_iob_rdat=ERR_DATA, tout_err=1.
  - last := gnt, next state IDLE.
- iob_rdy is ignored in IDLE and ERR. A late slave response after timeout is dropped.
- The non-granted master always sees rdy=0 and rdat=0. m*_iob_rdat=0 whenever its rdy=0.
- The ungranted master's val may toggle freely; the arbiter samples it only in IDLE.
- Writes and reads are treated identically. wen is forwarded, never interpreted.

Decomposition:
- Shared package/include cirno9_iob_pkg: state encoding (IDLE=2'd0, BUSY=2'd1, ERR=2'd2), `IOB_ERR_DATA default, iob field widths (ADR 32, WEN 4, DAT 32).
- Flops built from the existing dffr cell.
- One natural sub-module: cirno9_iob_rr2 (2-way round-robin picker: req[1:0], last → gnt, any).

Test Plan:
- Single read: m0 val, adr=32'h3000_0010; slave rdy 1 cycle after iob_val with rdat=32'h1234_5678 -> m0_rdy 1 cycle, m0_rdat=32'h1234_5678, iob_val high exactly 1 cycle.
- Contention: m0 and m1 val in the same cycle, both held -> grants m0, m1, m0, m1 in order, with a 1-cycle IDLE gap between each.
- Write pass-through: m1 wen=4'b0011, wdat=32'hA5A5_0000, adr=32'h1000_0004 -> iob_* equal m1 payload while iob_val=1; m0_rdy never asserts.
- Timeout: m0 adr=32'h5000_0000, slave never rdy -> after 16 BUSY cycles, m0_rdy=1 with rdat=32'hDEAD_BEEF, tout_err pulse, tout_adr=32'h5000_0000; a late iob_rdy is ignored.
- Reset mid-BUSY: assert rst_n=0 asynchronously -> iob_val and all rdy drop immediately. After release, m0 wins a simultaneous request.
- Abort: m1 granted, drops val before rdy -> return to IDLE, no m1_rdy, next simultaneous request still goes to m1 (last unchanged).
